// File: rtl/mode_ctrl.sv
// -----------------------------------------------------------------------------
// mode_ctrl -- front-panel controller for the digital clock.
//
// Three debounced, active-low keys set the display mode (clock, alarm or
// stopwatch), step through the time-set fields, and produce one-clock increment
// strobes. They also run and clear the stopwatch and drive a blink enable for
// the field being set. The clock, alarm, watch and display blocks only count
// and show what this block tells them.
//
// Optional feature macro: AUTO_REPEAT_EN
//   When it is defined, holding key_inc in a SET state produces repeat strobes
//   after REPEAT_DLY_MS ticks, then one every REPEAT_MS ticks. blink is held at
//   1 while repeating. When it is undefined, each press gives exactly one
//   strobe.
//
// Parameters:
//   BLINK_MS       tick_ms pulses per blink half-period while setting
//   REPEAT_DLY_MS  hold ticks before auto-repeat starts (AUTO_REPEAT_EN only)
//   REPEAT_MS      ticks between auto-repeat strobes    (AUTO_REPEAT_EN only)
//
// Ports:
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous reset, active-low
//   tick_ms    in   1  one-clk pulse per millisecond
//   key_mode   in   1  debounced key, active-low
//   key_sel    in   1  debounced key, active-low
//   key_inc    in   1  debounced key, active-low
//   mode       out  2  0=clock 1=alarm 2=stopwatch
//   set_act    out  1  high while a time field is being set
//   field      out  2  0=hour 1=minute 2=second (valid while set_act=1)
//   inc_pulse  out  1  one-clk strobe: increment `field` of the selected block
//   watch_run  out  1  stopwatch running level
//   watch_clr  out  1  one-clk strobe: clear stopwatch
//   blink      out  1  0 = blank the selected field
// -----------------------------------------------------------------------------
module mode_ctrl #(
  parameter int BLINK_MS      = 500,
  parameter int REPEAT_DLY_MS = 600,
  parameter int REPEAT_MS     = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_ms,
  input  logic       key_mode,
  input  logic       key_sel,
  input  logic       key_inc,
  output logic [1:0] mode,
  output logic       set_act,
  output logic [1:0] field,
  output logic       inc_pulse,
  output logic       watch_run,
  output logic       watch_clr,
  output logic       blink
);

  // The millisecond counters are sized for the largest interval parameter.
  localparam int MAX_A  = (BLINK_MS > REPEAT_DLY_MS) ? BLINK_MS : REPEAT_DLY_MS;
  localparam int MAX_MS = (MAX_A > REPEAT_MS) ? MAX_A : REPEAT_MS;
  localparam int MS_W   = $clog2(MAX_MS) + 1;
  localparam logic [MS_W-1:0] BLINK_END = MS_W'(BLINK_MS - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Key bit order in the vectors below: {mode, sel, inc}.
  logic [2:0] key_p0, key_p1, key_p2;
  logic [2:0] fall;
  logic       mode_ev, sel_ev, inc_ev;

  logic [1:0] mode_nxt, field_nxt;
  logic       run_nxt, clr_nxt, inc_nxt;
  logic       enter_set;

  logic [MS_W-1:0] ms_cnt;
  logic            blink_ph;
  logic            rep_fire;

  // Stage p0/p1: two-flop synchroniser. Stage p2: previous synchronised level.
  // All stages preset to 1 so that no key reads as pressed out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= '1;
      key_p1 <= '1;
      key_p2 <= '1;
    end else begin
      key_p0 <= {key_mode, key_sel, key_inc};
      key_p1 <= key_p0;
      key_p2 <= key_p1;
    end
  end

  // A press is a 1->0 step on the synchronised level. When presses arrive in
  // the same cycle, mode beats sel and sel beats inc. The losers are dropped.
  assign fall    = key_p2 & ~key_p1;
  assign mode_ev = fall[2];
  assign sel_ev  = fall[1] & ~fall[2];
  assign inc_ev  = fall[0] & ~fall[1] & ~fall[2];

  // State register, plus the registered outputs that the FSM decides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      mode      <= 2'd0;
      field     <= 2'd0;
      watch_run <= 1'b0;
      watch_clr <= 1'b0;
      inc_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode      <= mode_nxt;
      field     <= field_nxt;
      watch_run <= run_nxt;
      watch_clr <= clr_nxt;
      inc_pulse <= inc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    field_nxt = field;
    run_nxt   = watch_run;
    clr_nxt   = 1'b0;
    inc_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (mode_ev) begin
          mode_nxt = (mode == 2'd2) ? 2'd0 : mode + 2'd1;
        end else if (sel_ev) begin
          if (mode == 2'd2) begin
            // A running stopwatch cannot be cleared.
            clr_nxt = ~watch_run;
          end else begin
            state_nxt = SET_H;
            field_nxt = 2'd0;
          end
        end else if (inc_ev && mode == 2'd2) begin
          run_nxt = ~watch_run;
        end
      end
      SET_H: begin
        if (sel_ev) begin
          state_nxt = SET_M;
          field_nxt = 2'd1;
        end else if (inc_ev) begin
          inc_nxt = 1'b1;
        end
      end
      SET_M: begin
        if (sel_ev) begin
          state_nxt = SET_S;
          field_nxt = 2'd2;
        end else if (inc_ev) begin
          inc_nxt = 1'b1;
        end
      end
      SET_S: begin
        // field keeps its last value (seconds) after returning to RUN.
        if (sel_ev) begin
          state_nxt = RUN;
        end else if (inc_ev) begin
          inc_nxt = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    // A repeat strobe merges with a real press into a single pulse.
    inc_nxt = inc_nxt | rep_fire;
  end

  assign set_act   = (state != RUN);
  assign enter_set = (state_nxt != state) && (state_nxt != RUN);

  // Blink phase: restart at 1 on every entry to a SET state, then toggle every
  // BLINK_MS ticks. The >= compare keeps the counter from running past its end
  // value, so a wrap can never cause a false toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt   <= '0;
      blink_ph <= 1'b1;
    end else if (state_nxt == RUN || enter_set) begin
      ms_cnt   <= '0;
      blink_ph <= 1'b1;
    end else if (tick_ms) begin
      if (ms_cnt >= BLINK_END) begin
        ms_cnt   <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        ms_cnt <= ms_cnt + MS_W'(1);
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [MS_W-1:0] DLY_END = MS_W'(REPEAT_DLY_MS - 1);
  localparam logic [MS_W-1:0] REP_END = MS_W'(REPEAT_MS - 1);

  logic [MS_W-1:0] hold_cnt;
  logic            repeating;
  logic            hold_ok;

  // The hold time counts only while inc stays down in a stable SET state. A
  // release, or any change of state, restarts it.
  assign hold_ok  = ~key_p1[0] && (state != RUN) && (state_nxt == state);
  assign rep_fire = hold_ok && tick_ms &&
                    (repeating ? (hold_cnt >= REP_END) : (hold_cnt >= DLY_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (!hold_ok) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (tick_ms) begin
      if (rep_fire) begin
        hold_cnt  <= '0;
        repeating <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + MS_W'(1);
      end
    end
  end

  assign blink = blink_ph | repeating;
`else
  assign rep_fire = 1'b0;
  assign blink    = blink_ph;
`endif

endmodule

// File: tb/tb_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mode_ctrl -- self-checking bench for mode_ctrl.
// A behavioural model tracks the panel state from the key presses, applying
// them three clocks after each key falls. Every falling clock edge the outputs
// are compared against that model. Directed sequences add literal checks that
// pin the model to hand-derived values.
// -----------------------------------------------------------------------------
module tb_mode_ctrl;

  localparam int BLINK = 4;
  localparam int DLY   = 10;
  localparam int RMS   = 3;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       tick_ms  = 1'b0;
  logic       key_mode = 1'b1;
  logic       key_sel  = 1'b1;
  logic       key_inc  = 1'b1;
  logic [1:0] mode, field;
  logic       set_act, inc_pulse, watch_run, watch_clr, blink;

  int checks  = 0;
  int errors  = 0;
  int inc_cnt = 0;
  int clr_cnt = 0;

  mode_ctrl #(
    .BLINK_MS      (BLINK),
    .REPEAT_DLY_MS (DLY),
    .REPEAT_MS     (RMS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_ms   (tick_ms),
    .key_mode  (key_mode),
    .key_sel   (key_sel),
    .key_inc   (key_inc),
    .mode      (mode),
    .set_act   (set_act),
    .field     (field),
    .inc_pulse (inc_pulse),
    .watch_run (watch_run),
    .watch_clr (watch_clr),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic [2:0] kh [4];       // key samples at this edge and the three before it
  int         m_mode, m_fld, m_n;
  bit         m_set, m_run, m_clr, m_inc;
  bit         pm, ps, pi, changed, prev_set;
`ifdef AUTO_REPEAT_EN
  int         m_h;
`endif

  task automatic model_reset();
    for (int i = 0; i < 4; i++) kh[i] = 3'b111;
    m_mode = 0; m_fld = 0; m_n = 0;
    m_set = 0; m_run = 0; m_clr = 0; m_inc = 0;
`ifdef AUTO_REPEAT_EN
    m_h = 0;
`endif
  endtask

  task automatic model_step();
    kh[3] = kh[2]; kh[2] = kh[1]; kh[1] = kh[0];
    kh[0] = {key_mode, key_sel, key_inc};
    // A key low at the edge two back but high three back acts on this edge.
    pm = kh[3][2] && !kh[2][2];
    ps = kh[3][1] && !kh[2][1] && !pm;
    pi = kh[3][0] && !kh[2][0] && !pm && !ps;
    prev_set = m_set;
    changed  = 0;
    m_inc = 0;
    m_clr = 0;
    if (!m_set) begin
      if (pm) m_mode = (m_mode + 1) % 3;
      else if (ps) begin
        if (m_mode == 2) m_clr = !m_run;
        else begin m_set = 1; m_fld = 0; changed = 1; end
      end else if (pi && m_mode == 2) m_run = !m_run;
    end else begin
      if (ps) begin
        changed = 1;
        if (m_fld == 2) m_set = 0;
        else m_fld = m_fld + 1;
      end else if (pi) m_inc = 1;
    end
    if (!m_set || changed) m_n = 0;
    else if (tick_ms) m_n = m_n + 1;
`ifdef AUTO_REPEAT_EN
    if (kh[2][0] || !prev_set || changed) m_h = 0;
    else if (tick_ms) begin
      m_h = m_h + 1;
      if (m_h >= DLY && ((m_h - DLY) % RMS) == 0) m_inc = 1;
    end
`endif
  endtask

  function automatic logic exp_blink();
    if (!m_set) return 1'b1;
`ifdef AUTO_REPEAT_EN
    if (m_h >= DLY) return 1'b1;
`endif
    return ((m_n / BLINK) % 2) == 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // -------------------------------------------------------- per-cycle compare
  always @(negedge clk) begin
    checks++;
    if (mode !== 2'(m_mode) || set_act !== m_set || field !== 2'(m_fld) ||
        inc_pulse !== m_inc || watch_run !== m_run || watch_clr !== m_clr ||
        blink !== exp_blink()) begin
      errors++;
      $display("FAIL outputs t=%0t got mode=%0d set=%0b fld=%0d inc=%0b run=%0b clr=%0b blink=%0b want mode=%0d set=%0b fld=%0d inc=%0b run=%0b clr=%0b blink=%0b",
               $time, mode, set_act, field, inc_pulse, watch_run, watch_clr, blink,
               m_mode, m_set, m_fld, m_inc, m_run, m_clr, exp_blink());
    end
    if (inc_pulse === 1'b1) inc_cnt++;
    if (watch_clr === 1'b1) clr_cnt++;
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic t);
    tick_ms = t;
    @(posedge clk);
    #2;
    tick_ms = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  // mask bits {mode, sel, inc}: the keys fall together and release together.
  task automatic press(input logic [2:0] mask);
    key_mode = ~mask[2];
    key_sel  = ~mask[1];
    key_inc  = ~mask[0];
    idle(6);
    key_mode = 1'b1;
    key_sel  = 1'b1;
    key_inc  = 1'b1;
    idle(6);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      step(1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"},  int'(mode), 0);
    chk({tag, "_set"},   int'(set_act), 0);
    chk({tag, "_field"}, int'(field), 0);
    chk({tag, "_inc"},   int'(inc_pulse), 0);
    chk({tag, "_run"},   int'(watch_run), 0);
    chk({tag, "_clr"},   int'(watch_clr), 0);
    chk({tag, "_blink"}, int'(blink), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------- stimulus
  int c0;
  initial begin
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    chk_reset_vals("rst");

    // Mode cycling, including the exact press-to-change latency.
    key_mode = 1'b0;
    idle(2);
    chk("mode_lat2", int'(mode), 0);
    idle(1);
    chk("mode_lat3", int'(mode), 1);
    idle(3);
    key_mode = 1'b1;
    idle(6);
    press(3'b100);
    chk("mode_2", int'(mode), 2);
    press(3'b100);
    chk("mode_0", int'(mode), 0);
    chk("mode_set", int'(set_act), 0);

    // Time setting from clock mode.
    press(3'b010);
    chk("seth_set", int'(set_act), 1);
    chk("seth_fld", int'(field), 0);
    c0 = inc_cnt;
    press(3'b001);
    press(3'b001);
    chk("seth_incs", inc_cnt - c0, 2);
    chk("seth_fld2", int'(field), 0);
    press(3'b010);
    chk("setm_fld", int'(field), 1);
    press(3'b010);
    chk("sets_fld", int'(field), 2);
    press(3'b010);
    chk("run_set", int'(set_act), 0);
    chk("run_fld", int'(field), 2);

    // Stopwatch.
    press(3'b100);
    press(3'b100);
    chk("sw_mode", int'(mode), 2);
    press(3'b001);
    chk("sw_run1", int'(watch_run), 1);
    c0 = clr_cnt;
    press(3'b010);
    chk("sw_noclr", clr_cnt - c0, 0);
    press(3'b001);
    chk("sw_run0", int'(watch_run), 0);
    c0 = clr_cnt;
    press(3'b010);
    chk("sw_clr", clr_cnt - c0, 1);
    press(3'b001);
    press(3'b100);
    press(3'b100);
    chk("sw_bg_mode", int'(mode), 1);
    chk("sw_bg_run", int'(watch_run), 1);

    // Same-cycle priority inside setting.
    press(3'b010);
    press(3'b010);
    chk("pri_fld_m", int'(field), 1);
    c0 = inc_cnt;
    press(3'b101);
    chk("pri_mi_inc", inc_cnt - c0, 0);
    chk("pri_mi_mode", int'(mode), 1);
    chk("pri_mi_fld", int'(field), 1);
    press(3'b011);
    chk("pri_si_fld", int'(field), 2);
    chk("pri_si_inc", inc_cnt - c0, 0);
    chk("pri_si_set", int'(set_act), 1);

    // Blink in the freshly entered SET_S.
    chk("blink_start", int'(blink), 1);
    ticks(3);
    chk("blink_t3", int'(blink), 1);
    ticks(1);
    chk("blink_t4", int'(blink), 0);
    ticks(3);
    chk("blink_t7", int'(blink), 0);
    ticks(1);
    chk("blink_t8", int'(blink), 1);
    ticks(5);
    chk("blink_t13", int'(blink), 0);

    // Asynchronous reset in the middle of setting.
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Holding inc in SET_M.
    press(3'b010);
    press(3'b010);
    chk("hold_fld", int'(field), 1);
    c0 = inc_cnt;
    key_inc = 1'b0;
    idle(4);
    ticks(20);
    key_inc = 1'b1;
    idle(6);
`ifdef AUTO_REPEAT_EN
    chk("hold_pulses", inc_cnt - c0, 5);
`else
    chk("hold_pulses", inc_cnt - c0, 1);
`endif
    press(3'b010);
    press(3'b010);
    chk("end_set", int'(set_act), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
